// File: rtl/detect_event_monitor_pkg.sv
// rtl/detect_event_monitor_pkg.sv - shared types and defaults for detect_event_monitor
// Purpose: FSM state encoding and default parameter values used by the monitor.
// Ports: none (package).
package detect_mon_pkg;

  typedef enum logic {
    MON_IDLE = 1'b0,
    MON_RUN  = 1'b1
  } mon_state_t;

  localparam int DEF_WINDOW = 64;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_TS_W   = 32;

  // Bits needed to hold a per-window hit count of 0..window inclusive.
  function automatic int hits_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/detect_event_monitor_if.sv
// rtl/detect_event_monitor_if.sv - window report valid/ready channel
// Purpose: carries per-window hit-count reports from the monitor to the host side.
// Ports (signals):
//   rpt_valid  report available (monitor -> host)
//   rpt_ready  host accepts report (host -> monitor)
//   rpt_hits   mealy hits in the reported window (monitor -> host)
// Modports: master = monitor side, slave = host side.
interface detect_event_monitor_if #(
  parameter int HITS_W = 7
);
  logic              rpt_valid;
  logic              rpt_ready;
  logic [HITS_W-1:0] rpt_hits;

  modport master (output rpt_valid, output rpt_hits, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_hits, output rpt_ready);
endinterface

// File: rtl/detect_event_monitor_sat_counter.sv
// rtl/detect_event_monitor_sat_counter.sv - saturating up-counter with sync clear
// Purpose: counts inc pulses, sticks at all-ones; clr has priority over inc.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   clr      synchronous clear
//   inc      increment request
//   q        count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/detect_event_monitor.sv
// rtl/detect_event_monitor.sv - 1011-detector hit monitor with windowed reports
// Purpose: counts mealy hits, checks that each moore pulse trails its mealy pulse
//   by one cycle, and issues per-window hit-count reports over a valid/ready channel.
// Optional feature: MON_TIMESTAMP_EN adds a free-running timestamp and ts_last.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             1 = run windows, 0 = idle
//   clr            sync clear of totals and sticky flags
//   mealy_hit      detector mealy pulse
//   moore_hit      detector moore pulse
//   busy           FSM in RUN
//   total_hits     saturating mealy hit count while RUN
//   err_cnt        saturating mismatch-cycle count
//   mismatch_err   sticky mismatch flag
//   rpt_ovf        sticky: window ended while a report was still pending
//   ts_last        timestamp of last mealy hit (0 without MON_TIMESTAMP_EN)
//   rpt            report channel (master side)
module detect_event_monitor
  import detect_mon_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int TS_W   = DEF_TS_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   mealy_hit,
  input  logic                   moore_hit,
  output logic                   busy,
  output logic [CNT_W-1:0]       total_hits,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   mismatch_err,
  output logic                   rpt_ovf,
  output logic [TS_W-1:0]        ts_last,
  detect_event_monitor_if.master rpt
);

  localparam int HITS_W = hits_width(WINDOW);
  localparam int WC_W   = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);

  mon_state_t        state;
  mon_state_t        state_nxt;
  logic              run;
  logic              hit_run;
  logic              mismatch;
  logic              win_end;
  logic              accept;
  logic [HITS_W-1:0] win_total;

  logic              exp_q;
  logic [WC_W-1:0]   win_cnt;
  logic [HITS_W-1:0] win_hits;
  logic              rpt_valid_q;
  logic [HITS_W-1:0] rpt_hits_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MON_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      MON_IDLE: if (en)  state_nxt = MON_RUN;
      MON_RUN: begin
        run = 1'b1;
        if (!en) state_nxt = MON_IDLE;
      end
      default:  state_nxt = MON_IDLE;
    endcase
  end

  assign busy      = run;
  assign hit_run   = run & mealy_hit;
  // exp_q holds last cycle's mealy pulse; the moore pulse must equal it.
  assign mismatch  = run & (moore_hit != exp_q);
  assign win_end   = run & (win_cnt == WIN_LAST);
  assign accept    = rpt_valid_q & rpt.rpt_ready;
  // A hit on the window-end cycle still belongs to the closing window.
  assign win_total = win_hits + HITS_W'(hit_run);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= mealy_hit;
    end
  end

  // Leaving RUN discards the partial window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt  <= '0;
      win_hits <= '0;
    end else if (!run || win_end) begin
      win_cnt  <= '0;
      win_hits <= '0;
    end else begin
      win_cnt  <= win_cnt + WC_W'(1);
      win_hits <= win_total;
    end
  end

  // An accept on the window-end cycle frees the slot for the new report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_valid_q <= 1'b0;
      rpt_hits_q  <= '0;
    end else if (win_end && (!rpt_valid_q || accept)) begin
      rpt_valid_q <= 1'b1;
      rpt_hits_q  <= win_total;
    end else if (accept) begin
      rpt_valid_q <= 1'b0;
    end
  end

  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_hits  = rpt_hits_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_ovf      <= 1'b0;
      mismatch_err <= 1'b0;
    end else if (clr) begin
      rpt_ovf      <= 1'b0;
      mismatch_err <= 1'b0;
    end else begin
      if (win_end && rpt_valid_q && !accept) rpt_ovf <= 1'b1;
      if (mismatch) mismatch_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (hit_run),
    .q       (total_hits)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (mismatch),
    .q       (err_cnt)
  );

`ifdef MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_last <= '0;
    end else if (clr) begin
      ts_last <= '0;
    end else if (hit_run) begin
      ts_last <= ts;
    end
  end
`else
  assign ts_last = '0;
`endif

endmodule
